// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//   Purpose : bit-serial magnitude comparator sequencer. It feeds a one-bit
//             comparator cell MSB-first, then folds the cell's per-bit
//             verdicts into a word verdict {gt, eq, lt}.
//   Latency : res_valid rises WIDTH edges after the accepting edge. With
//             SERIAL_CMP_EARLY_EXIT_EN defined, it rises (index from MSB of
//             the first differing bit)+1 edges after that edge; all-equal
//             operands still take WIDTH edges.
//   Backpressure: one comparison in flight. in_ready is high only in IDLE,
//             and in_valid seen while in_ready is low is dropped, not queued.
//             The result is held stable while res_valid && !res_ready.
//
// Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN (early exit on first decision).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_a, in_b are WIDTH-bit operands
//   bit_a, bit_b        current MSB-first bit pair to the one-bit cell (0 outside SHIFT)
//   cmp_y               cell verdict [2]=A>B [1]=A==B [0]=A<B, sampled each SHIFT edge
//   res_valid/res_ready result handshake
//   res_y               word verdict (same encoding), 3'b000 when an error was seen
//   res_err             a non-one-hot cmp_y was sampled during this comparison
`timescale 1ns/1ps

module serial_word_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             bit_a,
  output logic             bit_b,
  input  logic [2:0]       cmp_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_y,
  output logic             res_err
);

  // Bit counter only has to hold WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] VERDICT_GT = 3'b100;
  localparam logic [2:0] VERDICT_EQ = 3'b010;
  localparam logic [2:0] VERDICT_LT = 3'b001;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("serial_word_comparator: WIDTH must be in 2..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_dec;
  logic             r_decided;
  logic             r_err;

  logic             w_accept;
  logic             w_decisive;
  logic             w_onehot;
  logic             w_last_bit;
  logic             w_early;

  // ---------------------------------------------------------------------------
  // Verdict classification of the cell output sampled this edge.
  // ---------------------------------------------------------------------------
  assign w_decisive = (cmp_y == VERDICT_GT) || (cmp_y == VERDICT_LT);
  assign w_onehot   = w_decisive || (cmp_y == VERDICT_EQ);
  assign w_last_bit = (r_cnt == '0);
  assign w_accept   = (r_state == S_IDLE) && in_valid;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // Only the first decisive bit ends the walk; a corrupt verdict never does.
  assign w_early = !r_decided && w_decisive;
`else
  assign w_early = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. Every output is a function of registered state
  // only, so bit_a/bit_b -> cell -> cmp_y never closes a combinational loop.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    res_y       = 3'b000;
    res_err     = 1'b0;
    bit_a       = 1'b0;
    bit_b       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        bit_a = r_sh_a[WIDTH-1];
        bit_b = r_sh_b[WIDTH-1];
        if (w_last_bit || w_early) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        res_valid = 1'b1;
        // A corrupted walk cannot be trusted, so no verdict bit is asserted.
        res_y     = r_err ? 3'b000 : r_dec;
        res_err   = r_err;
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, bit counter, decision and sticky error.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_a    <= '0;
      r_sh_b    <= '0;
      r_cnt     <= '0;
      r_dec     <= VERDICT_EQ;
      r_decided <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sh_a    <= in_a;
        r_sh_b    <= in_b;
        r_cnt     <= CW'(WIDTH - 1);
        r_dec     <= VERDICT_EQ;
        r_decided <= 1'b0;
        r_err     <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        r_sh_a <= {r_sh_a[WIDTH-2:0], 1'b0};
        r_sh_b <= {r_sh_b[WIDTH-2:0], 1'b0};
        r_cnt  <= r_cnt - CW'(1);

        // The first differing bit from the MSB owns the verdict; later
        // bits cannot overturn it.
        if (!r_decided && w_decisive) begin
          r_dec     <= cmp_y;
          r_decided <= 1'b1;
        end

        if (!w_onehot) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake invariants
  // ---------------------------------------------------------------------------
  a_no_overlap : assert property (@(posedge clk) disable iff (rst)
    !(in_ready && res_valid));

  a_result_held : assert property (@(posedge clk) disable iff (rst)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_y) && $stable(res_err)));

endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator
//   Purpose : randomized and directed stimulus for serial_word_comparator,
//             with an ideal one-bit comparator cell modelled in the bench
//             and a transaction-level reference model checked every cycle.
//   Latency/backpressure: exercised through held-off res_ready and
//             in_valid pulses while the block is busy.
`timescale 1ns/1ps

module tb_serial_word_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         bit_a;
  logic         bit_b;
  logic [2:0]   cmp_y;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [2:0]   res_y;
  logic         res_err;

  logic         inj_on  = 1'b0;
  int           inj_idx = -1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Ideal one-bit comparator cell, with an override to corrupt one verdict.
  assign cmp_y = inj_on ? 3'b011
                        : {bit_a & ~bit_b, bit_a ~^ bit_b, ~bit_a & bit_b};

  serial_word_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .bit_a     (bit_a),
    .bit_b     (bit_b),
    .cmp_y     (cmp_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_err   (res_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [31:0] t;
    t = $urandom;
    return t[W-1:0];
  endfunction

  // Word verdict straight from magnitude arithmetic.
  function automatic logic [2:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // Edges from acceptance to res_valid.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return W - i;
    end
`endif
    return W;
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction model: phase 0 idle, 1 presenting bits, 2 holding a result.
  // ---------------------------------------------------------------------------
  int           m_phase = 0;
  int           m_k = 0;
  int           m_L = W;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [2:0]   m_y = 3'b000;
  logic         m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_a     = in_a;
          m_b     = in_b;
          m_k     = 0;
          m_L     = ref_lat(in_a, in_b);
          m_err   = (inj_idx >= 0) && (inj_idx < m_L);
          m_y     = m_err ? 3'b000 : ref_y(in_a, in_b);
          m_phase = 1;
        end
        1: begin
          m_k++;
          if (m_k == m_L) m_phase = 2;
        end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  // Compare process: {in_ready, res_valid, res_y, res_err, bit_a, bit_b}.
  always @(negedge clk) begin
    logic [7:0] exp_v;
    case (m_phase)
      0:       exp_v = {1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
      1:       exp_v = {1'b0, 1'b0, 3'b000, 1'b0, m_a[W-1-m_k], m_b[W-1-m_k]};
      default: exp_v = {1'b0, 1'b1, m_y, m_err, 1'b0, 1'b0};
    endcase
    chk("cycle_outputs", {in_ready, res_valid, res_y, res_err, bit_a, bit_b}, exp_v);
  end

  // One comparison: accept, walk bits, optionally hold off res_ready while
  // pulsing in_valid, then consume the result.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj, input int hold,
                         output int lat, output logic [2:0] y, output logic e,
                         output logic [W-1:0] sa, output logic [W-1:0] sb);
    int n;
    int L;
    inj_idx = inj;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = rnd_w(); in_b = rnd_w();   // operands must already be captured
    sa = '0; sb = '0;
    n = 0;
    while (n < 4 * W) begin
      if (res_valid) break;
      inj_on = (n == inj);
      sa = {sa[W-2:0], bit_a};
      sb = {sb[W-2:0], bit_b};
      @(posedge clk); #1; n++;
    end
    inj_on = 1'b0;
    lat = n;
    y = res_y;
    e = res_err;
    L = ref_lat(a, b);
    chk("res_valid_timeout", res_valid, 1);
    chk("latency", lat, L);
    chk("result", y, ((inj >= 0) && (inj < L)) ? 3'b000 : ref_y(a, b));
    chk("result_err", e, ((inj >= 0) && (inj < L)) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      if (i % 2 == 0) begin
        in_valid = 1'b1; in_a = rnd_w(); in_b = rnd_w();
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("hold_res_y", res_y, y);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("result_consumed", res_valid, 0);
    chk("back_to_idle", in_ready, 1);
    inj_idx = -1;
  endtask

  initial begin
    int           lat;
    logic [2:0]   y;
    logic         e;
    logic [W-1:0] sa, sb, a, b;
    int           mode, inj, hold;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, res_valid, res_y, res_err, bit_a, bit_b}, 8'b1000_0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Equal operands.
    run_cmp(8'hA5, 8'hA5, -1, 0, lat, y, e, sa, sb);
    chk("a5_a5_lat", lat, 8);
    chk("a5_a5_y", y, 3'b010);
    chk("a5_a5_err", e, 0);

    // MSB decides.
    run_cmp(8'h80, 8'h7F, -1, 0, lat, y, e, sa, sb);
    chk("80_7f_y", y, 3'b100);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    chk("80_7f_lat", lat, 1);
`else
    chk("80_7f_lat", lat, 8);
`endif

    // LSB decides; bit stream observed MSB-first.
    run_cmp(8'h00, 8'h01, -1, 0, lat, y, e, sa, sb);
    chk("00_01_y", y, 3'b001);
    chk("00_01_lat", lat, 8);
    chk("00_01_bits_a", sa, 8'h00);
    chk("00_01_bits_b", sb, 8'h01);

    // Result held 5 cycles with in_valid pulses ignored, then next pair.
    run_cmp(8'h55, 8'h11, -1, 5, lat, y, e, sa, sb);
    chk("55_11_y", y, 3'b100);
    run_cmp(8'h3C, 8'h3D, -1, 0, lat, y, e, sa, sb);
    chk("3c_3d_y", y, 3'b001);

    // Reset during the 4th SHIFT cycle.
    in_a = 8'hFF; in_b = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_reset_outputs", {in_ready, res_valid, res_y, res_err, bit_a, bit_b}, 8'b1000_0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_no_result", res_valid, 0);
    run_cmp(8'h12, 8'h12, -1, 0, lat, y, e, sa, sb);
    chk("12_12_y", y, 3'b010);

    // Corrupt verdict on the 2nd bit, then a clean comparison.
    run_cmp(8'h40, 8'h40, 1, 0, lat, y, e, sa, sb);
    chk("inject_y", y, 3'b000);
    chk("inject_err", e, 1);
    run_cmp(8'h40, 8'h40, -1, 0, lat, y, e, sa, sb);
    chk("clean_y", y, 3'b010);
    chk("clean_err", e, 0);

    // Randomized comparisons.
    for (int it = 0; it < 40; it++) begin
      a = rnd_w();
      mode = $urandom_range(0, 3);
      inj = -1;
      if (mode == 0) begin
        b = a;
        if ($urandom_range(0, 2) == 0) inj = $urandom_range(0, W - 1);
      end else if (mode == 1) begin
        b = a ^ (W'(1) << $urandom_range(0, W - 1));
      end else begin
        b = rnd_w();
      end
      hold = $urandom_range(0, 3);
      run_cmp(a, b, inj, hold, lat, y, e, sa, sb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
